// File: rtl/k2red_ln_shift_stream_if.sv
// rtl/k2red_ln_shift_stream_if.sv - beat/result stream bundle for k2red_ln_shift_stream
// Tag signals exist only when K2RED_TAG_EN is defined.
interface k2red_ln_shift_stream_if #(
  parameter int LOG_Q   = 32,
  parameter int LOG_L   = 4,
  parameter int N_TERMS = 3
`ifdef K2RED_TAG_EN
  ,
  parameter int TAG_W   = 8
`endif
);
  logic                     in_valid;
  logic                     in_ready;
  logic [2*LOG_Q-1:0]       A;
  logic [LOG_Q-1:0]         Q;
  logic [N_TERMS*LOG_L-1:0] l;
  logic [N_TERMS-1:0]       sgn;
  logic                     out_valid;
  logic                     out_ready;
  logic [LOG_Q-1:0]         C2;
`ifdef K2RED_TAG_EN
  logic [TAG_W-1:0]         in_tag;
  logic [TAG_W-1:0]         out_tag;

  modport master (output in_valid, A, Q, l, sgn, in_tag, out_ready,
                  input  in_ready, out_valid, C2, out_tag);
  modport slave  (input  in_valid, A, Q, l, sgn, in_tag, out_ready,
                  output in_ready, out_valid, C2, out_tag);
`else
  modport master (output in_valid, A, Q, l, sgn, out_ready,
                  input  in_ready, out_valid, C2);
  modport slave  (input  in_valid, A, Q, l, sgn, out_ready,
                  output in_ready, out_valid, C2);
`endif
endinterface

// File: rtl/k2red_ln_shift_stream.sv
// rtl/k2red_ln_shift_stream.sv - streaming K2-RED reducer, C2 = k^2*A mod Q, q = k*2^M + 1
// K2RED_TAG_EN adds a sideband tag that travels with each beat.
module k2red_ln_shift_stream #(
  parameter int LOG_Q     = 32,
  parameter int M         = 17,
  parameter int LOG_L     = 4,
  parameter int N_TERMS   = 3,
  parameter int SPEED_OPT = 1
`ifdef K2RED_TAG_EN
  ,
  parameter int TAG_W     = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  k2red_ln_shift_stream_if.slave bus
);
  localparam int K0    = LOG_Q - 1 - M;
  localparam int L_MAX = (1 << LOG_L) - 1;
  localparam int LOG_C = 2*LOG_Q - M + 1;
  localparam int AH_W  = 2*LOG_Q - M;
  localparam int SH1_W = L_MAX + M;
  localparam int SH2_W = L_MAX + M + 1;
  localparam int B1_W  = K0 + M;
  localparam int B2_W  = K0 + M + 1;

  typedef struct packed {
    logic [LOG_Q-1:0]         q;
    logic [N_TERMS*LOG_L-1:0] l;
    logic [N_TERMS-1:0]       sgn;
  } ctx_t;

  logic en;
  logic out_v;
  logic [LOG_Q-1:0] c2_r;
  ctx_t in_ctx;

  assign en            = !out_v || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_v;
  assign bus.C2        = c2_r;
  assign in_ctx        = {bus.Q, bus.l, bus.sgn};

  // Stage 1: split A at bit M
  logic             s1_v;
  logic [AH_W-1:0]  s1_ah;
  logic [M-1:0]     s1_al;
  ctx_t             s1_ctx;
  always_ff @(posedge clk) begin
    if (rst) s1_v <= 1'b0;
    else if (en) s1_v <= bus.in_valid;
    if (en) begin
      s1_ah  <= bus.A[2*LOG_Q-1:M];
      s1_al  <= bus.A[M-1:0];
      s1_ctx <= in_ctx;
    end
  end

  logic [B1_W-1:0]               sh1_base;
  logic [N_TERMS-1:0][SH1_W-1:0] sh1_term;
  always_comb begin
    sh1_base = {s1_al, {K0{1'b0}}};
    for (int i = 0; i < N_TERMS; i++)
      sh1_term[i] = SH1_W'(s1_al) << s1_ctx.l[i*LOG_L +: LOG_L];
  end

  logic                          p2_v;
  logic [B1_W-1:0]               p2_base;
  logic [N_TERMS-1:0][SH1_W-1:0] p2_term;
  logic [AH_W-1:0]               p2_ah;
  ctx_t                          p2_ctx;
  generate
    if (SPEED_OPT != 0) begin : g_reg2
      always_ff @(posedge clk) begin
        if (rst) p2_v <= 1'b0;
        else if (en) p2_v <= s1_v;
        if (en) begin
          p2_base <= sh1_base;
          p2_term <= sh1_term;
          p2_ah   <= s1_ah;
          p2_ctx  <= s1_ctx;
        end
      end
    end else begin : g_comb2
      assign p2_v    = s1_v;
      assign p2_base = sh1_base;
      assign p2_term = sh1_term;
      assign p2_ah   = s1_ah;
      assign p2_ctx  = s1_ctx;
    end
  endgenerate

  // Stage 2: C1 = k*AL - AH, congruent to k*A since k*2^M = -1 mod q
  logic signed [LOG_C-1:0] c1_sum;
  always_comb begin
    c1_sum = LOG_C'(p2_base) - LOG_C'(p2_ah);
    for (int i = 0; i < N_TERMS; i++)
      c1_sum = p2_ctx.sgn[i] ? c1_sum - LOG_C'(p2_term[i]) : c1_sum + LOG_C'(p2_term[i]);
  end

  logic                    c1_v;
  logic signed [LOG_C-1:0] c1_r;
  ctx_t                    c1_ctx;
  always_ff @(posedge clk) begin
    if (rst) c1_v <= 1'b0;
    else if (en) c1_v <= p2_v;
    if (en) begin
      c1_r   <= c1_sum;
      c1_ctx <= p2_ctx;
    end
  end

  // Stage 3: signed high part, non-negative low part
  logic                      s3_v;
  logic signed [LOG_C-M-1:0] s3_h;
  logic [M-1:0]              s3_l;
  ctx_t                      s3_ctx;
  always_ff @(posedge clk) begin
    if (rst) s3_v <= 1'b0;
    else if (en) s3_v <= c1_v;
    if (en) begin
      s3_h   <= c1_r[LOG_C-1:M];
      s3_l   <= c1_r[M-1:0];
      s3_ctx <= c1_ctx;
    end
  end

  logic [B2_W-1:0]               sh2_base;
  logic [N_TERMS-1:0][SH2_W-1:0] sh2_term;
  always_comb begin
    sh2_base = {1'b0, s3_l, {K0{1'b0}}};
    for (int i = 0; i < N_TERMS; i++)
      sh2_term[i] = SH2_W'(s3_l) << s3_ctx.l[i*LOG_L +: LOG_L];
  end

  logic                          p4_v;
  logic [B2_W-1:0]               p4_base;
  logic [N_TERMS-1:0][SH2_W-1:0] p4_term;
  logic signed [LOG_C-M-1:0]     p4_h;
  logic [LOG_Q-1:0]              p4_q;
  logic [N_TERMS-1:0]            p4_sgn;
  generate
    if (SPEED_OPT != 0) begin : g_reg4
      always_ff @(posedge clk) begin
        if (rst) p4_v <= 1'b0;
        else if (en) p4_v <= s3_v;
        if (en) begin
          p4_base <= sh2_base;
          p4_term <= sh2_term;
          p4_h    <= s3_h;
          p4_q    <= s3_ctx.q;
          p4_sgn  <= s3_ctx.sgn;
        end
      end
    end else begin : g_comb4
      assign p4_v    = s3_v;
      assign p4_base = sh2_base;
      assign p4_term = sh2_term;
      assign p4_h    = s3_h;
      assign p4_q    = s3_ctx.q;
      assign p4_sgn  = s3_ctx.sgn;
    end
  endgenerate

  logic signed [LOG_C-1:0] c2_sum;
  always_comb begin
    c2_sum = LOG_C'(p4_base) - {{M{p4_h[LOG_C-M-1]}}, p4_h};
    for (int i = 0; i < N_TERMS; i++)
      c2_sum = p4_sgn[i] ? c2_sum - LOG_C'(p4_term[i]) : c2_sum + LOG_C'(p4_term[i]);
  end

  logic                    c2i_v;
  logic signed [LOG_C-1:0] c2i_r;
  logic [LOG_Q-1:0]        c2i_q;
  always_ff @(posedge clk) begin
    if (rst) c2i_v <= 1'b0;
    else if (en) c2i_v <= p4_v;
    if (en) begin
      c2i_r <= c2_sum;
      c2i_q <= p4_q;
    end
  end

  // Stage 5: C2int lies in (-Q, 2Q), so one correction in either direction suffices
  logic signed [LOG_C-1:0] q_ext;
  logic [LOG_Q-1:0]        c2_next;
  always_comb begin
    q_ext = {{(LOG_C-LOG_Q){1'b0}}, c2i_q};
    if (c2i_r >= q_ext)        c2_next = c2i_r[LOG_Q-1:0] - c2i_q;
    else if (c2i_r[LOG_C-1])   c2_next = c2i_r[LOG_Q-1:0] + c2i_q;
    else                       c2_next = c2i_r[LOG_Q-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v <= 1'b0;
      c2_r  <= '0;
    end else if (en) begin
      out_v <= c2i_v;
      if (c2i_v) c2_r <= c2_next;
    end
  end

`ifdef K2RED_TAG_EN
  // Every stage advances on en alike, so a plain delay line keeps tags aligned with data
  localparam int DELAY = 5 + 2*SPEED_OPT;
  logic [DELAY-2:0][TAG_W-1:0] tag_pipe;
  logic [TAG_W-1:0]            out_tag_r;
  assign bus.out_tag = out_tag_r;
  always_ff @(posedge clk) begin
    if (en) tag_pipe <= {tag_pipe[DELAY-3:0], bus.in_tag};
    if (rst) out_tag_r <= '0;
    else if (en && c2i_v) out_tag_r <= tag_pipe[DELAY-2];
  end
`endif
endmodule

// File: tb/tb_k2red_ln_shift_stream.sv
// tb/tb_k2red_ln_shift_stream.sv - directed-vector bench for k2red_ln_shift_stream
// K2RED_TAG_EN adds out_tag checks.
module tb_k2red_ln_shift_stream;
  localparam int LOG_Q     = 32;
  localparam int M         = 17;
  localparam int LOG_L     = 4;
  localparam int N_TERMS   = 3;
  localparam int SPEED_OPT = 1;
  localparam int DELAY     = 5 + 2*SPEED_OPT;

  // k1=16409 (l={0,3,5},sgn=010), k2=16387 (l={0,0,0},sgn=000), k3=16362 (l={1,2,4},sgn=111)
  localparam logic [31:0] Q1 = 32'd2150760449;
  localparam logic [31:0] Q2 = 32'd2147876865;
  localparam logic [31:0] Q3 = 32'd2144600065;
  localparam logic [11:0] L1 = 12'h530;
  localparam logic [11:0] L2 = 12'h000;
  localparam logic [11:0] L3 = 12'h421;
  localparam logic [2:0]  S1 = 3'b010;
  localparam logic [2:0]  S2 = 3'b000;
  localparam logic [2:0]  S3 = 3'b111;
  localparam int N_VEC = 15;

  typedef struct {
    logic [63:0] a;
    logic [31:0] q;
    logic [11:0] l;
    logic [2:0]  sgn;
    logic [31:0] exp;
    logic [7:0]  tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  int   seen;
  vec_t tbl[N_VEC];
  vec_t send_q[$];
  vec_t exp_q[$];
  vec_t v;

`ifdef K2RED_TAG_EN
  k2red_ln_shift_stream_if #(.LOG_Q(LOG_Q), .LOG_L(LOG_L), .N_TERMS(N_TERMS), .TAG_W(8)) bus ();
  k2red_ln_shift_stream #(.LOG_Q(LOG_Q), .M(M), .LOG_L(LOG_L), .N_TERMS(N_TERMS),
                          .SPEED_OPT(SPEED_OPT), .TAG_W(8))
    dut (.clk(clk), .rst(rst), .bus(bus));
`else
  k2red_ln_shift_stream_if #(.LOG_Q(LOG_Q), .LOG_L(LOG_L), .N_TERMS(N_TERMS)) bus ();
  k2red_ln_shift_stream #(.LOG_Q(LOG_Q), .M(M), .LOG_L(LOG_L), .N_TERMS(N_TERMS),
                          .SPEED_OPT(SPEED_OPT))
    dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: k^2*A mod q with k recovered from q itself
  function automatic logic [31:0] model(input logic [63:0] a, input logic [31:0] q);
    logic [127:0] k, t;
    k = 128'((q - 32'd1) >> M);
    t = (128'(a) % 128'(q)) * ((k * k) % 128'(q)) % 128'(q);
    return t[31:0];
  endfunction

  task automatic set_vec(input int i, input logic [63:0] a, input logic [31:0] q,
                         input logic [11:0] l, input logic [2:0] s, input logic [31:0] e);
    tbl[i].a = a; tbl[i].q = q; tbl[i].l = l; tbl[i].sgn = s;
    tbl[i].exp = e; tbl[i].tag = 8'(i);
  endtask

  task automatic drive(input vec_t d, input logic vld);
    bus.in_valid = vld;
    bus.A        = d.a;
    bus.Q        = d.q;
    bus.l        = d.l;
    bus.sgn      = d.sgn;
`ifdef K2RED_TAG_EN
    bus.in_tag   = d.tag;
`endif
  endtask

  task automatic run_stream(input bit rnd, input string name);
    int total, got, n, first_out, last_out;
    bit stall;
    logic [31:0] held_c2;
    vec_t e;
`ifdef K2RED_TAG_EN
    logic [7:0] held_tag;
    held_tag = '0;
`endif
    total = send_q.size(); got = 0; n = 0; stall = 1'b0;
    first_out = -1; last_out = -1; held_c2 = '0;
    while (got < total && n < 5000) begin
      @(negedge clk);
      n++;
      if (stall) begin
        check({name, "_stall_valid"}, bus.out_valid, 1);
        check({name, "_stall_c2"}, bus.C2, held_c2);
`ifdef K2RED_TAG_EN
        check({name, "_stall_tag"}, bus.out_tag, held_tag);
`endif
      end
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (send_q.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) drive(send_q[0], 1'b1);
      else bus.in_valid = 1'b0;
      #1;
      check({name, "_in_ready"}, bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.in_valid && bus.in_ready) exp_q.push_back(send_q.pop_front());
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check({name, "_spurious"}, bus.out_valid, 0);
        else begin
          e = exp_q.pop_front();
          check({name, "_c2"}, bus.C2, e.exp);
`ifdef K2RED_TAG_EN
          check({name, "_tag"}, bus.out_tag, e.tag);
`endif
          got++;
          if (first_out < 0) first_out = n;
          last_out = n;
        end
      end
      stall   = bus.out_valid && !bus.out_ready;
      held_c2 = bus.C2;
`ifdef K2RED_TAG_EN
      held_tag = bus.out_tag;
`endif
    end
    check({name, "_count"}, got, total);
    if (!rnd) check({name, "_throughput"}, last_out - first_out + 1, total);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    send_q.delete();
    exp_q.delete();
  endtask

  initial begin
    set_vec(0,  64'd0,                                Q1, L1, S1, 32'd0);
    set_vec(1,  64'd1,                                Q1, L1, S1, 32'd269255281);
    set_vec(2,  64'(Q1),                              Q1, L1, S1, 32'd0);
    set_vec(3,  64'(Q1 - 32'd1) * 64'(Q1 - 32'd1),    Q1, L1, S1, 32'd269255281);
    set_vec(4,  64'd2,                                Q1, L1, S1, 32'd538510562);
    set_vec(5,  64'd131072,                           Q1, L1, S1, 32'd2150744040);
    set_vec(6,  64'(Q1) + 64'd1,                      Q1, L1, S1, 32'd269255281);
    set_vec(7,  64'd1,                                Q2, L2, S2, 32'd268533769);
    set_vec(8,  64'd131072,                           Q2, L2, S2, 32'd2147860478);
    set_vec(9,  64'd1,                                Q3, L3, S3, 32'd267715044);
    set_vec(10, 64'd131072,                           Q3, L3, S3, 32'd2144583703);
    set_vec(11, 64'(Q1) * 64'(Q1) - 64'd1,            Q1, L1, S1, 32'd1881505168);
    set_vec(12, 64'(Q3) - 64'd1,                      Q3, L3, S3, 32'd1876885021);
    set_vec(13, 64'd131071,                           Q1, L1, S1, 32'd1881488759);
    set_vec(14, 64'd26214408,                         Q1, L1, S1, 32'd2150760448);

    drive(tbl[0], 1'b0);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_c2", bus.C2, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
`ifdef K2RED_TAG_EN
    check("post_rst_tag", bus.out_tag, 0);
`endif

    // Single beat A=0: latency and one-cycle out_valid pulse
    drive(tbl[0], 1'b1);
    cyc = 0; seen = 0;
    while (cyc < 20 && seen == 0) begin
      @(posedge clk); cyc++;
      @(negedge clk); bus.in_valid = 1'b0;
      if (bus.out_valid) seen = 1;
    end
    check("lat_cycles", cyc, DELAY);
    check("lat_c2", bus.C2, 0);
    @(negedge clk);
    check("lat_one_pulse", bus.out_valid, 0);

    for (int i = 0; i < N_VEC; i++) send_q.push_back(tbl[i]);
    run_stream(1'b0, "tbl");

    for (int i = 0; i < 256; i++) begin
      v.q   = ($urandom_range(0, 1) == 1) ? Q1 : Q3;
      v.l   = (v.q == Q1) ? L1 : L3;
      v.sgn = (v.q == Q1) ? S1 : S3;
      v.a   = {$urandom(), $urandom()} % (64'(v.q) * 64'(v.q));
      v.exp = model(v.a, v.q);
      v.tag = 8'(i);
      send_q.push_back(v);
    end
    run_stream(1'b1, "rnd");

    // Reset with four beats in flight: none of them may emerge
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(tbl[4], 1'b1);
    end
    @(negedge clk); bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst_flush_valid", seen, 0);
    check("rst_flush_c2", bus.C2, 0);
    check("rst_flush_in_ready", bus.in_ready, 1);

    drive(tbl[1], 1'b1);
    cyc = 0; seen = 0;
    while (cyc < 20 && seen == 0) begin
      @(posedge clk); cyc++;
      @(negedge clk); bus.in_valid = 1'b0;
      if (bus.out_valid) seen = 1;
    end
    check("post_flush_lat", cyc, DELAY);
    check("post_flush_c2", bus.C2, 32'd269255281);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
